// File: rtl/cache_tg_pkg.sv
// Shared types and the data-pattern function for the cache port traffic generator.
package cache_tg_pkg;

    localparam int unsigned TG_CFG_BASE_W  = 64;
    localparam int unsigned TG_CFG_WORDS_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_RD_REQ  = 3'd2,
        ST_TAG     = 3'd3,
        ST_WAIT_RV = 3'd4,
        ST_DONE    = 3'd5
    } tg_state_e;

    typedef enum logic {
        PH_WRITE = 1'b0,
        PH_READ  = 1'b1
    } tg_phase_e;

    // Per-port sweep configuration, wide enough for any supported parameter set.
    typedef struct packed {
        logic [TG_CFG_BASE_W-1:0]  base;
        logic [TG_CFG_WORDS_W-1:0] num_words;
    } tg_cfg_t;

    function automatic logic [63:0] tg_pattern(input logic [31:0] addr, input logic [31:0] seed);
        return {addr ^ seed, ~addr ^ seed};
    endfunction

endpackage

// File: rtl/cache_tg_port.sv
// One request channel: write sweep, read-back sweep, compare, timeout and protocol checks.
module cache_tg_port
    import cache_tg_pkg::*;
#(
    parameter int unsigned IndexWidth    = 12,
    parameter int unsigned TagWidth      = 44,
    parameter int unsigned DataWidth     = 64,
    parameter int unsigned MaxWords      = 256,
    parameter int unsigned TimeoutCycles = 1024,
    parameter logic [31:0] Seed          = 32'hA5A5_0F0F
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  tg_cfg_t               cfg_i,
    input  logic                  gnt_i,
    input  logic                  rvalid_i,
    input  logic [DataWidth-1:0]  rdata_i,
    output logic                  req_o,
    output logic                  we_o,
    output logic [7:0]            be_o,
    output logic [1:0]            size_o,
    output logic [IndexWidth-1:0] index_o,
    output logic [TagWidth-1:0]   tag_o,
    output logic                  tag_valid_o,
    output logic [DataWidth-1:0]  wdata_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [15:0]           err_cnt_o,
    output logic                  proto_err_o,
    output logic                  timeout_o
);

    localparam int unsigned AW  = TagWidth + IndexWidth;
    localparam int unsigned WAW = AW - 3;
    localparam int unsigned NW  = $clog2(MaxWords + 1);
    localparam int unsigned TW  = $clog2(TimeoutCycles + 1);

    tg_state_e      state_q, state_d;
    tg_phase_e      phase_q, phase_d;
    logic [NW-1:0]  k_q, k_d, num_q, num_d;
    logic [WAW-1:0] base_q, base_d;
    logic [TW-1:0]  to_q, to_d;
    logic [15:0]    err_q, err_d;
    logic           proto_q, proto_d, tmo_q, tmo_d;
    logic           word_done, rv_expected, mismatch;
    logic [31:0]    cur_lo;
    logic [63:0]    exp_data;
    logic [AW-1:0]  addr_d;

    logic                  req_q, we_q, tag_valid_q, busy_q, done_q;
    logic [7:0]            be_q;
    logic [1:0]            size_q;
    logic [IndexWidth-1:0] index_q;
    logic [TagWidth-1:0]   tag_q;
    logic [DataWidth-1:0]  wdata_q;

    logic unused_cfg_c;
    assign unused_cfg_c = ^{cfg_i.base[TG_CFG_BASE_W-1:AW], cfg_i.base[2:0],
                            cfg_i.num_words[TG_CFG_WORDS_W-1:NW]};

    // Expected read data is the pattern of the word currently in flight.
    assign cur_lo   = {base_q[28:0] + 29'(k_q), 3'b000};
    assign exp_data = tg_pattern(cur_lo, Seed);

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        k_d         = k_q;
        num_d       = num_q;
        base_d      = base_q;
        to_d        = to_q;
        err_d       = err_q;
        proto_d     = proto_q;
        tmo_d       = tmo_q;
        word_done   = 1'b0;
        mismatch    = 1'b0;
        rv_expected = (state_q == ST_WAIT_RV) || (state_q == ST_TAG && phase_q == PH_READ);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    base_d  = cfg_i.base[AW-1:3];
                    num_d   = NW'(cfg_i.num_words);
                    k_d     = '0;
                    phase_d = PH_WRITE;
                    err_d   = '0;
                    proto_d = 1'b0;
                    tmo_d   = 1'b0;
                    state_d = (num_d == '0) ? ST_DONE : ST_WR_REQ;
                end
            end
            ST_WR_REQ, ST_RD_REQ: begin
                if (gnt_i) begin
                    state_d = ST_TAG;
                end else if (to_q == TW'(TimeoutCycles - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            ST_TAG: begin
                if (phase_q == PH_WRITE || rvalid_i) word_done = 1'b1;
                else                                 state_d   = ST_WAIT_RV;
            end
            ST_WAIT_RV: begin
                if (rvalid_i) begin
                    word_done = 1'b1;
                end else if (to_q == TW'(TimeoutCycles - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Advance to the next word, switch to read-back, or finish.
        if (word_done) begin
            mismatch = (phase_q == PH_READ) && (rdata_i != DataWidth'(exp_data));
            if (mismatch && err_q != 16'hFFFF) err_d = err_q + 16'd1;
            if ((NW+1)'(k_q) + (NW+1)'(1) < (NW+1)'(num_q)) begin
                k_d     = k_q + NW'(1);
                state_d = (phase_q == PH_WRITE) ? ST_WR_REQ : ST_RD_REQ;
            end else if (phase_q == PH_WRITE) begin
                k_d     = '0;
                phase_d = PH_READ;
                state_d = ST_RD_REQ;
            end else begin
                state_d = ST_DONE;
            end
        end

        if (state_d != state_q) to_d = '0;
        if (rvalid_i && !rv_expected) proto_d = 1'b1;
    end

    assign addr_d = {base_d + WAW'(k_d), 3'b000};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            phase_q <= PH_WRITE;
            k_q     <= '0;
            num_q   <= '0;
            base_q  <= '0;
            to_q    <= '0;
            err_q   <= '0;
            proto_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            k_q     <= k_d;
            num_q   <= num_d;
            base_q  <= base_d;
            to_q    <= to_d;
            err_q   <= err_d;
            proto_q <= proto_d;
            tmo_q   <= tmo_d;
        end
    end

    // Request-side outputs are registered from the next state so they change only on clk.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            be_q        <= '0;
            size_q      <= '0;
            index_q     <= '0;
            tag_q       <= '0;
            tag_valid_q <= 1'b0;
            wdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            req_q       <= (state_d == ST_WR_REQ) || (state_d == ST_RD_REQ);
            we_q        <= (state_d == ST_WR_REQ);
            be_q        <= ((state_d == ST_WR_REQ) || (state_d == ST_RD_REQ)) ? 8'hFF : 8'h00;
            size_q      <= ((state_d == ST_WR_REQ) || (state_d == ST_RD_REQ)) ? 2'b11 : 2'b00;
            index_q     <= addr_d[IndexWidth-1:0];
            tag_q       <= addr_d[AW-1:IndexWidth];
            tag_valid_q <= (state_d == ST_TAG);
            wdata_q     <= (state_d == ST_WR_REQ) ? DataWidth'(tg_pattern(addr_d[31:0], Seed)) : '0;
            busy_q      <= (state_d != ST_IDLE) && (state_d != ST_DONE);
            done_q      <= (state_d == ST_DONE);
        end
    end

    assign req_o       = req_q;
    assign we_o        = we_q;
    assign be_o        = be_q;
    assign size_o      = size_q;
    assign index_o     = index_q;
    assign tag_o       = tag_q;
    assign tag_valid_o = tag_valid_q;
    assign wdata_o     = wdata_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_cnt_o   = err_q;
    assign proto_err_o = proto_q;
    assign timeout_o   = tmo_q;

endmodule

// File: rtl/cache_port_traffic_gen.sv
// NumPorts independent D$ request-port stimulus engines with flattened vector ports.
module cache_port_traffic_gen
    import cache_tg_pkg::*;
#(
    parameter int unsigned NumPorts      = 3,
    parameter int unsigned IndexWidth    = 12,
    parameter int unsigned TagWidth      = 44,
    parameter int unsigned DataWidth     = 64,
    parameter int unsigned MaxWords      = 256,
    parameter int unsigned TimeoutCycles = 1024,
    parameter logic [31:0] Seed          = 32'hA5A5_0F0F
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic [NumPorts-1:0]                      start_i,
    input  logic [NumPorts*(TagWidth+IndexWidth)-1:0] base_addr_i,
    input  logic [NumPorts*$clog2(MaxWords+1)-1:0]   num_words_i,
    output logic [NumPorts-1:0]                      req_o,
    output logic [NumPorts-1:0]                      we_o,
    output logic [NumPorts*8-1:0]                    be_o,
    output logic [NumPorts*2-1:0]                    size_o,
    output logic [NumPorts*IndexWidth-1:0]           index_o,
    output logic [NumPorts*TagWidth-1:0]             tag_o,
    output logic [NumPorts-1:0]                      tag_valid_o,
    output logic [NumPorts-1:0]                      kill_o,
    output logic [NumPorts*DataWidth-1:0]            wdata_o,
    input  logic [NumPorts-1:0]                      gnt_i,
    input  logic [NumPorts-1:0]                      rvalid_i,
    input  logic [NumPorts*DataWidth-1:0]            rdata_i,
    output logic [NumPorts-1:0]                      busy_o,
    output logic [NumPorts-1:0]                      done_o,
    output logic [NumPorts*16-1:0]                   err_cnt_o,
    output logic [NumPorts-1:0]                      proto_err_o,
    output logic [NumPorts-1:0]                      timeout_o
);

    localparam int unsigned AW = TagWidth + IndexWidth;
    localparam int unsigned NW = $clog2(MaxWords + 1);

    assign kill_o = '0;

    for (genvar p = 0; p < NumPorts; p++) begin : g_port
        tg_cfg_t cfg;
        assign cfg = '{base:      TG_CFG_BASE_W'(base_addr_i[p*AW +: AW]),
                       num_words: TG_CFG_WORDS_W'(num_words_i[p*NW +: NW])};

        cache_tg_port #(
            .IndexWidth   (IndexWidth),
            .TagWidth     (TagWidth),
            .DataWidth    (DataWidth),
            .MaxWords     (MaxWords),
            .TimeoutCycles(TimeoutCycles),
            .Seed         (Seed)
        ) u_port (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .start_i    (start_i[p]),
            .cfg_i      (cfg),
            .gnt_i      (gnt_i[p]),
            .rvalid_i   (rvalid_i[p]),
            .rdata_i    (rdata_i[p*DataWidth +: DataWidth]),
            .req_o      (req_o[p]),
            .we_o       (we_o[p]),
            .be_o       (be_o[p*8 +: 8]),
            .size_o     (size_o[p*2 +: 2]),
            .index_o    (index_o[p*IndexWidth +: IndexWidth]),
            .tag_o      (tag_o[p*TagWidth +: TagWidth]),
            .tag_valid_o(tag_valid_o[p]),
            .wdata_o    (wdata_o[p*DataWidth +: DataWidth]),
            .busy_o     (busy_o[p]),
            .done_o     (done_o[p]),
            .err_cnt_o  (err_cnt_o[p*16 +: 16]),
            .proto_err_o(proto_err_o[p]),
            .timeout_o  (timeout_o[p])
        );
    end

endmodule
